mem_copy_engine: RTL and testbench
==================================

# mem_copy_engine

Block-copy engine that sits directly upstream of the 256×8 data memory and owns its single address/data/write-enable port. When idle it passes processor load/store traffic straight through. When started, it copies `len` bytes from `src` to `dst` through that same port and asserts `busy` so the processor stalls. Completion is signalled by a one-cycle `done` pulse.

## Interface
Parameters:
- `AW`, 8, address width (memory depth 2^AW bytes)
- `DW`, 8, data width

Ports:
- `clk`  in  1  system clock; single clock domain. The data memory writes on the falling edge of `clk`.
- `reset_n`  in  1  synchronous, active-low reset
- `start`  in  1  copy request; sampled only in IDLE
- `src`  in  AW  source base address; captured on accepted start
- `dst`  in  AW  destination base address; captured on accepted start
- `len`  in  AW  byte count, 0..255; captured on accepted start
- `cpu_addr`  in  AW  processor address
- `cpu_dat`  in  DW  processor store data
- `cpu_wr_en`  in  1  processor store enable
- `cpu_dat_out`  out  DW  read data returned to processor; always equals `mem_dat_out`
- `mem_addr`  out  AW  to data memory address
- `mem_dat_in`  out  DW  to data memory write data
- `mem_wr_en`  out  1  to data memory write enable
- `mem_dat_out`  in  DW  from data memory; combinational read of `mem_addr`
- `busy`  out  1  high in READ and WRITE; processor must stall
- `done`  out  1  one-cycle completion pulse

## Operation
- States: IDLE, READ, WRITE, DONE.
- **IDLE**
  - Port pass-through: `mem_addr=cpu_addr`, `mem_dat_in=cpu_dat`, `mem_wr_en=cpu_wr_en`.
  - On `start=1` with `len!=0`: capture `src`, `dst`, `len`, clear index `i`, go to READ.
  - On `start=1` with `len==0`: go to DONE; no memory access.
- **READ**
  - `mem_addr=src_q+i`, `mem_wr_en=0`.
  - At the next posedge, latch `mem_dat_out` into `buf_q` and go to WRITE.
- **WRITE**
  - `mem_addr=dst_q+i`, `mem_dat_in=buf_q`, `mem_wr_en=1`; the memory commits on the negedge of this cycle.
  - At the next posedge, `i<=i+1`. If `i+1==len_q` go to DONE, else go to READ.
- **DONE**
  - `done=1` for one cycle; pass-through is active again; go to IDLE.
- `cpu_*` inputs are ignored while `busy=1`. Processor stores issued during a copy are lost; stalling is the processor's responsibility.
- `start` is ignored in READ, WRITE and DONE. There is no queueing.
- Address arithmetic is modulo 2^AW: `src_q+i` and `dst_q+i` wrap 255→0. `i` is AW bits wide.
- Copy order is ascending. For an overlapping range with `dst>src` (and `dst<src+len`), the copy is defined as propagating the source bytes forward. This is intended behaviour, not an error.
- `src==dst` is legal: each byte is rewritten with its own value.

## Timing
- Latency: `start` accepted at posedge N; `done` is high in cycle N+2·len+1. For `len=0`, `done` is high in cycle N+1.
- Each byte takes 2 cycles (one READ, one WRITE). Exactly one `mem_wr_en` cycle per byte.
- `busy` is registered from state: it rises in the cycle after `start` is accepted and falls in the DONE cycle.
- Reset (`reset_n=0` at a posedge):
  - state goes to IDLE; `busy=0`, `done=0`;
  - `src_q`, `dst_q`, `len_q`, `i`, `buf_q` clear to 0.
- Reset mid-copy: the copy aborts immediately. Bytes already written stay in memory, no further writes occur, and no `done` pulse is generated.
- While `reset_n=0`, `mem_wr_en` follows `cpu_wr_en` (pass-through), because the state is IDLE.
- A `start` held high across DONE begins a new copy in the following IDLE cycle.

## Structure
- Shared package `mem_copy_pkg`:
  - `typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} copy_state_t`;
  - address and data width localparams, so the data memory and processor top reference one definition.
- Single module. The IDLE/engine port mux is three `assign` lines and does not justify a sub-module.
- Registers: `state`, `src_q`, `dst_q`, `len_q`, `i`, `buf_q`.

## Test plan
- **Basic copy:** preload mem[0x10..0x13]=A1,B2,C3,D4; start `src=0x10`, `dst=0x40`, `len=4` → mem[0x40..0x43]=A1,B2,C3,D4; `busy` high for 8 cycles; `done` in cycle 9; exactly 4 write cycles.
- **Zero length:** `len=0`, `src=0x20`, `dst=0x30` → `done` in cycle 1; `busy` never high; memory unchanged; no write cycle.
- **Wrap-around:** mem[0xFE]=11, mem[0xFF]=22, mem[0x00]=33; start `src=0xFE`, `dst=0x80`, `len=3` → mem[0x80..0x82]=11,22,33.
- **Overlap forward:** mem[0x00..0x03]=01,02,03,04; start `src=0x00`, `dst=0x01`, `len=3` → mem[0x00..0x03]=01,01,01,01.
- **Reset mid-copy:** start a `len=6` copy; drop `reset_n` during the 3rd WRITE → only 2 destination bytes written (3rd if its negedge preceded reset); state IDLE; no `done`; pass-through works on the next cycle.
- **Pass-through and ignored start:** in IDLE, `cpu_wr_en=1`, `cpu_addr=0x55`, `cpu_dat=0x9C` → mem[0x55]=0x9C. Pulse `start` again while `busy` → ignored; only one `done` is produced.

Source files
------------

// File: rtl/mem_copy_pkg.sv
// Shared definitions for the block-copy engine, the data memory and the processor top.
// One place for the address/data widths and the engine state encoding.
package mem_copy_pkg;

    localparam int unsigned MC_AW    = 8;
    localparam int unsigned MC_DW    = 8;
    localparam int unsigned MC_DEPTH = 1 << MC_AW;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } copy_state_t;

    // Modulo-2^MC_AW offset from a base address; wrap 255->0 falls out of the width.
    function automatic logic [MC_AW-1:0] mc_offset_addr(
        input logic [MC_AW-1:0] base,
        input logic [MC_AW-1:0] offset
    );
        return base + offset;
    endfunction

endpackage : mem_copy_pkg

// File: rtl/mem_copy_engine_if.sv
// Single address/data/write-enable port of the 256x8 data memory.
// The copy engine drives it as master; the memory is the slave.
interface mem_copy_engine_if #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 8
) ();

    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_dat_in;
    logic          mem_wr_en;
    logic [DW-1:0] mem_dat_out;

    modport master (
        output mem_addr,
        output mem_dat_in,
        output mem_wr_en,
        input  mem_dat_out
    );

    modport slave (
        input  mem_addr,
        input  mem_dat_in,
        input  mem_wr_en,
        output mem_dat_out
    );

endinterface : mem_copy_engine_if

// File: rtl/mem_copy_engine.sv
// Block-copy engine owning the data memory port: CPU pass-through when idle,
// ascending READ/WRITE byte copy from src to dst when started.
module mem_copy_engine
    import mem_copy_pkg::*;
#(
    parameter int unsigned AW = MC_AW,
    parameter int unsigned DW = MC_DW
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [AW-1:0] src,
    input  logic [AW-1:0] dst,
    input  logic [AW-1:0] len,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_dat,
    input  logic          cpu_wr_en,
    output logic [DW-1:0] cpu_dat_out,
    output logic          busy,
    output logic          done,
    mem_copy_engine_if.master mem_bus
);

    copy_state_t   state_q;
    logic [AW-1:0] src_q;
    logic [AW-1:0] dst_q;
    logic [AW-1:0] len_q;
    logic [AW-1:0] i_q;
    logic [DW-1:0] buf_q;
    logic          busy_q;
    logic          done_q;

    logic [AW-1:0] i_d;
    logic          last_s;
    logic [AW-1:0] rd_addr_s;
    logic [AW-1:0] wr_addr_s;

    // Index increment, last-byte detect and wrapping source/destination addresses.
    always_comb begin
        i_d       = i_q + AW'(1);
        last_s    = (i_d == len_q);
        rd_addr_s = src_q + i_q;
        wr_addr_s = dst_q + i_q;
    end

    // Memory port mux: engine owns the port in READ/WRITE, processor otherwise.
    assign mem_bus.mem_addr   = (state_q == READ)  ? rd_addr_s :
                                (state_q == WRITE) ? wr_addr_s : cpu_addr;
    assign mem_bus.mem_dat_in = (state_q == WRITE) ? buf_q : cpu_dat;
    assign mem_bus.mem_wr_en  = (state_q == WRITE) ? 1'b1 :
                                (state_q == READ)  ? 1'b0 : cpu_wr_en;

    assign cpu_dat_out = mem_bus.mem_dat_out;
    assign busy        = busy_q;
    assign done        = done_q;

    // Copy FSM with registered busy/done; reset aborts any copy in flight.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            i_q     <= '0;
            buf_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (len != '0) begin
                            src_q   <= src;
                            dst_q   <= dst;
                            len_q   <= len;
                            i_q     <= '0;
                            busy_q  <= 1'b1;
                            state_q <= READ;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                READ: begin
                    buf_q   <= mem_bus.mem_dat_out;
                    state_q <= WRITE;
                end
                WRITE: begin
                    i_q <= i_d;
                    if (last_s) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        state_q <= READ;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule : mem_copy_engine

// File: tb/tb_mem_copy_engine.sv
// Self-checking bench for mem_copy_engine: behavioural 256x8 memory, reference
// copy model feeding a scoreboard queue, plus cycle-accurate busy/done/write checks.
module tb_mem_copy_engine;
    import mem_copy_pkg::*;

    localparam int AW = MC_AW;
    localparam int DW = MC_DW;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [AW-1:0] src, dst, len;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_dat;
    logic          cpu_wr_en;
    logic [DW-1:0] cpu_dat_out;
    logic          busy, done;
    logic          clear_mem;

    mem_copy_engine_if #(.AW(AW), .DW(DW)) mem_bus ();

    mem_copy_engine #(.AW(AW), .DW(DW)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .src         (src),
        .dst         (dst),
        .len         (len),
        .cpu_addr    (cpu_addr),
        .cpu_dat     (cpu_dat),
        .cpu_wr_en   (cpu_wr_en),
        .cpu_dat_out (cpu_dat_out),
        .busy        (busy),
        .done        (done),
        .mem_bus     (mem_bus)
    );

    always #5 clk = ~clk;

    logic [7:0] mem     [0:255];
    logic [7:0] ref_mem [0:255];

    // Data memory: falling-edge write, combinational read.
    always @(negedge clk) begin
        if (clear_mem) begin
            for (int k = 0; k < 256; k++) mem[k] <= 8'h00;
        end else if (mem_bus.mem_wr_en) begin
            mem[mem_bus.mem_addr] <= mem_bus.mem_dat_in;
        end
    end
    assign mem_bus.mem_dat_out = mem[mem_bus.mem_addr];

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
    } exp_t;
    exp_t sb_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        cpu_addr  = a;
        cpu_dat   = d;
        cpu_wr_en = 1'b1;
        ref_mem[a] = d;
        @(posedge clk); #1;
        cpu_wr_en = 1'b0;
    endtask

    // Reference: ascending byte copy of the first n_done bytes, then expect all len dst bytes.
    task automatic model_copy(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
                              input int n_done);
        logic [7:0] off;
        exp_t e;
        for (int k = 0; k < n_done; k++) begin
            off = 8'(k);
            ref_mem[d + off] = ref_mem[s + off];
        end
        for (int k = 0; k < int'(l); k++) begin
            off    = 8'(k);
            e.addr = d + off;
            e.data = ref_mem[d + off];
            sb_q.push_back(e);
        end
    endtask

    task automatic push_exp(input logic [7:0] a);
        exp_t e;
        e.addr = a;
        e.data = ref_mem[a];
        sb_q.push_back(e);
    endtask

    task automatic drain_sb(input string tag);
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_eq(tag, {24'h0, mem[e.addr]}, {24'h0, e.data});
        end
    endtask

    // Launch a copy and watch a fixed window; cycle c is the c-th cycle after acceptance.
    task automatic run_copy(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
                            input int window, input int restart_at,
                            output int done_cyc, output int busy_cnt,
                            output int wr_cnt, output int done_cnt);
        done_cyc = 0; busy_cnt = 0; wr_cnt = 0; done_cnt = 0;
        @(posedge clk); #1;
        src = s; dst = d; len = l; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= window; c++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (mem_bus.mem_wr_en) wr_cnt++;
            if (done) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = c;
            end
            if (c == restart_at) begin
                src = 8'h00; dst = 8'hE0; len = 8'h02; start = 1'b1;
            end else if (c == restart_at + 1) begin
                start = 1'b0;
            end
        end
    endtask

    int dc, bc, wc, nc;

    initial begin
        for (int k = 0; k < 256; k++) ref_mem[k] = 8'h00;
        reset_n = 1'b0; start = 1'b0; src = '0; dst = '0; len = '0;
        cpu_addr = '0; cpu_dat = '0; cpu_wr_en = 1'b0; clear_mem = 1'b1;

        // Reset state and pass-through while held in reset.
        @(negedge clk);
        @(posedge clk); #1;
        clear_mem = 1'b0;
        cpu_addr = 8'h77; cpu_dat = 8'h5A; cpu_wr_en = 1'b1;
        ref_mem[8'h77] = 8'h5A;
        @(negedge clk);
        check_eq("rst_busy", {31'h0, busy}, 32'h0);
        check_eq("rst_done", {31'h0, done}, 32'h0);
        check_eq("rst_wr_pass", {31'h0, mem_bus.mem_wr_en}, 32'h1);
        check_eq("rst_addr_pass", {24'h0, mem_bus.mem_addr}, 32'h77);
        @(posedge clk); #1;
        cpu_wr_en = 1'b0;
        reset_n = 1'b1;
        push_exp(8'h77);
        drain_sb("rst_store");

        // Basic copy.
        cpu_write(8'h10, 8'hA1); cpu_write(8'h11, 8'hB2);
        cpu_write(8'h12, 8'hC3); cpu_write(8'h13, 8'hD4);
        model_copy(8'h10, 8'h40, 8'd4, 4);
        run_copy(8'h10, 8'h40, 8'd4, 12, 0, dc, bc, wc, nc);
        check_eq("basic_done_cyc", dc, 9);
        check_eq("basic_busy_cyc", bc, 8);
        check_eq("basic_wr_cyc", wc, 4);
        check_eq("basic_done_cnt", nc, 1);
        check_eq("basic_byte2", {24'h0, mem[8'h42]}, 32'hC3);
        drain_sb("basic_data");

        // Zero length.
        cpu_write(8'h20, 8'hEE); cpu_write(8'h30, 8'h3C);
        push_exp(8'h30);
        run_copy(8'h20, 8'h30, 8'd0, 5, 0, dc, bc, wc, nc);
        check_eq("zero_done_cyc", dc, 1);
        check_eq("zero_busy_cyc", bc, 0);
        check_eq("zero_wr_cyc", wc, 0);
        check_eq("zero_done_cnt", nc, 1);
        drain_sb("zero_mem");

        // Wrap-around source.
        cpu_write(8'hFE, 8'h11); cpu_write(8'hFF, 8'h22); cpu_write(8'h00, 8'h33);
        model_copy(8'hFE, 8'h80, 8'd3, 3);
        run_copy(8'hFE, 8'h80, 8'd3, 10, 0, dc, bc, wc, nc);
        check_eq("wrap_done_cyc", dc, 7);
        check_eq("wrap_wr_cyc", wc, 3);
        drain_sb("wrap_data");

        // Overlapping forward copy propagates the first byte.
        cpu_write(8'h00, 8'h01); cpu_write(8'h01, 8'h02);
        cpu_write(8'h02, 8'h03); cpu_write(8'h03, 8'h04);
        model_copy(8'h00, 8'h01, 8'd3, 3);
        push_exp(8'h00);
        run_copy(8'h00, 8'h01, 8'd3, 10, 0, dc, bc, wc, nc);
        check_eq("ovl_byte3", {24'h0, mem[8'h03]}, 32'h01);
        drain_sb("ovl_data");

        // Reset during the third WRITE: three bytes land, the rest untouched.
        for (int k = 0; k < 6; k++) begin
            cpu_write(8'h60 + 8'(k), 8'h90 + 8'(k));
            cpu_write(8'hA0 + 8'(k), 8'hF0 + 8'(k));
        end
        @(posedge clk); #1;
        src = 8'h60; dst = 8'hA0; len = 8'd6; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset_n = 1'b0;
        cpu_addr = 8'h12; cpu_wr_en = 1'b0;
        @(negedge clk);
        check_eq("abort_last_wr", {31'h0, mem_bus.mem_wr_en}, 32'h1);
        nc = 0; wc = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (done) nc++;
            if (mem_bus.mem_wr_en) wc++;
            if (c == 0) begin
                check_eq("abort_busy", {31'h0, busy}, 32'h0);
                check_eq("abort_addr_pass", {24'h0, mem_bus.mem_addr}, 32'h12);
            end
        end
        check_eq("abort_no_done", nc, 0);
        check_eq("abort_no_wr", wc, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        model_copy(8'h60, 8'hA0, 8'd6, 3);
        drain_sb("abort_data");

        // Pass-through store right after reset release, then read-back path.
        cpu_write(8'h55, 8'h9C);
        push_exp(8'h55);
        drain_sb("pass_store");
        cpu_addr = 8'h55;
        @(negedge clk);
        check_eq("pass_read", {24'h0, cpu_dat_out}, 32'h9C);

        // Second start while busy is ignored.
        cpu_write(8'hC0, 8'h5E); cpu_write(8'hC1, 8'h6F); cpu_write(8'hC2, 8'h70);
        model_copy(8'hC0, 8'hD0, 8'd3, 3);
        push_exp(8'hE0); push_exp(8'hE1);
        run_copy(8'hC0, 8'hD0, 8'd3, 14, 3, dc, bc, wc, nc);
        check_eq("ign_done_cnt", nc, 1);
        check_eq("ign_done_cyc", dc, 7);
        check_eq("ign_wr_cyc", wc, 3);
        drain_sb("ign_data");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_mem_copy_engine
